// File: rtl/kbd_fifo_slave.sv
// kbd_fifo_slave: Wishbone slave buffering PS/2 scan codes in a FIFO.
// Register map (ADDR[3:2]): 0 DATA (R, pops), 1 STATUS (R), 2 CTRL (W), 3 reserved.
// Optional build macro: KBD_FIFO_BREAK_FILTER_EN drops 0xF0 break prefixes and
// the byte following each one, so only make codes reach the CPU.
module kbd_fifo_slave #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ready_pulse,
   input  logic [7:0]            Keyboard_Data,
   input  logic                  STB,
   input  logic                  WE,
   input  logic [31:0]           ADDR,
   input  logic [31:0]           DAT_I,
   output logic [31:0]           DAT_O,
   output logic                  ACK,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Storage and bookkeeping
   logic [7:0]    r_mem [0:DEPTH-1];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [31:0]   r_dat;
   logic          r_ack;
   state_t        r_state;
   state_t        w_state_nxt;

   // Decode and datapath control
   logic [1:0]    w_addr;
   logic          w_start;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_ctrl;
   logic          w_flush;
   logic          w_ovf_clr;
   logic          w_accept;
   logic          w_push;
   logic          w_drop;
   logic [31:0]   w_rdata;
   logic          w_unused;

   assign w_addr   = ADDR[3:2];
   assign w_unused = ^{ADDR[31:4], ADDR[1:0], DAT_I[31:2]};

   // A transaction starts only from IDLE, so a long STB never repeats the action
   assign w_start   = (r_state == S_IDLE) && STB;
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop     = w_start && !WE && (w_addr == A_DATA) && !w_empty;
   assign w_ctrl    = w_start && WE && (w_addr == A_CTRL);
   assign w_flush   = w_ctrl && DAT_I[0];
   assign w_ovf_clr = w_ctrl && DAT_I[1];

`ifdef KBD_FIFO_BREAK_FILTER_EN
   logic r_brk;

   // Only bytes that are neither a break prefix nor the code after it are kept
   assign w_accept = ready_pulse && !r_brk && (Keyboard_Data != 8'hF0);

   // Break-pending flag: set by 0xF0, consumed by the next byte, cleared by flush
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_brk <= 1'b0;
      end else if (w_flush) begin
         r_brk <= 1'b0;
      end else if (ready_pulse) begin
         if (r_brk) begin
            r_brk <= 1'b0;
         end else if (Keyboard_Data == 8'hF0) begin
            r_brk <= 1'b1;
         end
      end
   end
`else
   assign w_accept = ready_pulse;
`endif

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
   assign w_push = w_accept && !w_flush && (!w_full || w_pop);
   assign w_drop = w_accept && !w_flush && w_full && !w_pop;

   // Handshake next-state: IDLE -> ACK (one cycle) -> WAIT until STB drops
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (STB)  w_state_nxt = S_ACK;
         S_ACK:            w_state_nxt = S_WAIT;
         S_WAIT: if (!STB) w_state_nxt = S_IDLE;
         default:          w_state_nxt = S_IDLE;
      endcase
   end

   // Read-data mux; writes and unmapped reads return zero
   always_comb begin
      w_rdata = '0;
      if (!WE) begin
         case (w_addr)
            A_DATA: begin
               if (!w_empty) begin
                  w_rdata = {23'b0, 1'b1, r_mem[r_rd_ptr]};
               end
            end
            A_STATUS: begin
               w_rdata = {16'b0, 8'(r_count), 5'b0, r_ovf, w_full, w_empty};
            end
            default: w_rdata = '0;
         endcase
      end
   end

   // Handshake state, ACK pulse and read-data capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_dat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_start;
         if (w_start) begin
            r_dat <= w_rdata;
         end
      end
   end

   // Pointers and occupancy; flush overrides any push or pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= Keyboard_Data;
      end
   end

   assign DAT_O = r_dat;
   assign ACK   = r_ack;
   assign level = r_count;

endmodule

// File: doc/kbd_fifo_slave.md
Name: kbd_fifo_slave

Overview:
- Wishbone slave that buffers PS/2 scan codes from the keyboard receiver (`ready_pulse` / `Keyboard_Data`).
- Lets the CPU read them through the intercon without losing bytes typed between polls.
- Sits downstream of the keyboard receiver and upstream of the Wishbone intercon, on one slave slot (`slave_STB` bit, `ACK`, 32-bit `DAT_O`).
- Adds a status register and a control register for flush and overflow clear.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 2..8.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset; clears all state
ready_pulse  input  1  one-cycle strobe: Keyboard_Data holds a new scan code
Keyboard_Data  input  8  scan code, valid when ready_pulse=1
STB  input  1  Wishbone strobe for this slave
WE  input  1  Wishbone write enable
ADDR  input  32  Wishbone byte address; only ADDR[3:2] decoded
DAT_I  input  32  Wishbone write data
DAT_O  output  32  Wishbone read data, registered
ACK  output  1  Wishbone acknowledge, one-cycle pulse
level  output  DEPTH_LOG2+1  current entry count (for LED/debug)

Behaviour:
- Reset (reset=0, async):
  - FIFO empty, read/write pointers 0, count 0, overflow flag 0.
  - DAT_O=0, ACK=0, handshake FSM in IDLE.
- Register map by ADDR[3:2]:
  - 0 DATA (R): {23'b0, valid, byte[7:0]}. Reading pops one entry if non-empty. Empty read returns 0 and does not pop.
  - 1 STATUS (R): {16'b0, count[7:0] zero-extended, 5'b0, overflow, full, empty}.
  - 2 CTRL (W): DAT_I[0]=1 flushes (pointers and count to 0). DAT_I[1]=1 clears overflow. Reads return 0.
  - 3: reserved. Reads return 0; writes ignored; still ACKed.
  - Writes to DATA/STATUS and reads of CTRL are ACKed with no effect.
- Handshake FSM (IDLE, ACK, WAIT):
  - IDLE, STB=1 → ACK state. In that same edge DAT_O is loaded, and the pop or control action is performed.
  - ACK state: ACK=1 for exactly one cycle → WAIT.
  - WAIT: remain until STB=0 → IDLE.
  - Exactly one pop per transaction regardless of how long STB is held.
  - Latency: ACK visible in the cycle after STB is first sampled high.
  - DAT_O holds its value until the next transaction.
- Push: ready_pulse=1 writes Keyboard_Data at the write pointer; pointer increments modulo 2^DEPTH_LOG2.
- Full and no simultaneous pop: the byte is dropped and overflow is set (sticky).
- Simultaneous push and pop:
  - Both take effect; count unchanged.
  - Legal when full: pop frees the slot first, no overflow.
  - When empty: pop is a no-op (returns 0), push stores normally, count becomes 1.
- Flush and push in the same cycle: flush wins, byte discarded, overflow not set.
- Overflow set and CTRL clear in the same cycle: set wins.
- `level`, `full`, `empty` are derived from the registered count:
  - full = (count == 2^DEPTH_LOG2)
  - empty = (count == 0)
- Reset asserted mid-transaction: ACK drops immediately; FSM returns to IDLE; FIFO contents are lost.

Optional Feature:
KBD_FIFO_BREAK_FILTER_EN
- Defined: a 1-bit "break pending" register filters the input stream.
  - A pushed 0xF0 is not stored; it sets break-pending.
  - The next byte is discarded and clears break-pending.
  - 0xE0 is stored normally and does not affect break-pending.
  - Flush and reset clear break-pending.
  - Result: only make codes reach the CPU.
- Undefined: every received byte, including 0xF0 and break codes, is stored unchanged.

Test Plan:
- Reset then read STATUS → DAT_O=0x00000001 (empty), ACK exactly one cycle after STB, DATA read → 0x00000000.
- Push 0x1C, 0x32; read DATA twice → 0x0000011C then 0x00000132; third read → 0x00000000; STATUS → 0x00000001.
- DEPTH_LOG2=4: push 17 bytes 0x01..0x11 with no reads → STATUS=0x00001006 (count 16, overflow, full); 16 DATA reads return 0x101..0x110; write CTRL 0x2 → overflow 0.
- Full FIFO, ready_pulse coincident with the pop cycle of a DATA read → count stays 16, overflow stays 0, newest byte read last.
- Hold STB high 5 cycles on a DATA read → single ACK pulse, count decrements by exactly 1; write CTRL 0x1 with ready_pulse in the same cycle → count 0.
- With KBD_FIFO_BREAK_FILTER_EN: push 0x1C, 0xF0, 0x1C, 0x32 → reads return 0x11C, 0x132, then empty. Without the macro: four entries stored.
